dma_page_address_unit: RTL and testbench

- Downstream address stage of the 8237A DMA controller; builds the full 24-bit system address for every DMA bus cycle.
- Latches the upper address byte A15–A8 that the controller multiplexes onto DB7_DB0 under ADSTB, and appends the low byte A7–A0.
- Prepends a per-channel 8-bit page register, selected by the active DACK.
- Detects 64K page wrap on each channel, reports it in a sticky status register, and optionally advances the page automatically.

---
 rtl/dma_page_address_unit.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_dma_page_address_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_page_address_unit.sv
`default_nettype none
// ============================================================================
// Module      : dma_page_address_unit
// Description : Downstream address stage of an 8237A-style DMA controller.
//               Builds the 24-bit system address {page, A15-A8, A7-A0} for
//               every DMA bus cycle. Latches the upper address byte that the
//               controller multiplexes onto DBIn under ADSTB, prepends the
//               per-channel page register selected by DACK, and detects 64K
//               page wrap within a service (sticky status + WrapIrq).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_CH    : number of DMA channels / page registers (1..4 supported,
//               RegAddr 4 is always the wrap status register)
//   PAGE_RST  : reset value of every page register
// Compile-time option
//   DMA_AUTO_PAGE_INC_EN : when defined, an increment wrap advances the page
//               of the serviced channel and a decrement wrap retreats it, so
//               transfers run linearly across 64K boundaries. When undefined
//               pages change only by CPU write.
// Ports
//   Clock, nReset        : clock, asynchronous active-low reset
//   nCSPage, nIOW, nIOR  : CPU register access strobes (active low)
//   RegAddr              : 0..NUM_CH-1 page registers, 4 wrap status
//   DBIn / DBOut / DBOE  : data bus in, register read data, read enable
//   ADSTB, AEN, A7_A0    : address strobe, address enable, low address byte
//   DACK                 : channel acknowledge, active high
//   SysAddr, AddrValid   : registered 24-bit address and its qualifier
//   WrapIrq              : OR of the sticky wrap status bits (registered)
// ============================================================================
module dma_page_address_unit #(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] PAGE_RST = 8'h00
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              nCSPage,
    input  logic              nIOW,
    input  logic              nIOR,
    input  logic [2:0]        RegAddr,
    input  logic [7:0]        DBIn,
    output logic [7:0]        DBOut,
    output logic              DBOE,
    input  logic              ADSTB,
    input  logic              AEN,
    input  logic [7:0]        A7_A0,
    input  logic [NUM_CH-1:0] DACK,
    output logic [23:0]       SysAddr,
    output logic              AddrValid,
    output logic              WrapIrq
);

    localparam int         c_CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] c_NUM_CH4  = 4'(NUM_CH);
    localparam logic [2:0] c_REG_STAT = 3'd4;

    // Address FSM encoding
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_STB = 2'd1;
    localparam logic [1:0] c_VALID    = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_nIowD;       // previous nIOW, for rising-edge detect
    logic              r_adstbD;      // previous ADSTB, for falling-edge detect
    logic [7:0]        r_upperLatch;  // follows DBIn while ADSTB is high
    logic [7:0]        r_upperCur;    // upper byte committed at ADSTB fall
    logic [7:0]        r_prevUpper;   // upper byte of the previous strobe
    logic              r_prevValid;   // r_prevUpper belongs to this service
    logic [c_CHW-1:0]  r_chan;        // channel currently in service
    logic [7:0]        r_page [NUM_CH];
    logic [NUM_CH-1:0] r_status;
    logic              r_wrapIrq;
    logic              r_addrValid;
    logic [23:0]       r_sysAddr;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic              w_dackOneHot;
    logic [c_CHW-1:0]  w_dackIdx;
    logic              w_adstbFall;
    logic              w_cpuWrite;
    logic              w_regIsPage;
    logic              w_pageWr;
    logic              w_statusWr;
    logic              w_newSvc;
    logic              w_inService;
    logic              w_strobeDone;
    logic              w_wrapInc;
    logic              w_wrapDec;
    logic [NUM_CH-1:0] w_setMask;
    logic [NUM_CH-1:0] w_clrMask;
    logic [7:0]        w_statusByte;
    logic [7:0]        w_readData;

    assign w_dackOneHot = (DACK != '0) && ((DACK & (DACK - NUM_CH'(1))) == '0);

    always_comb begin
        w_dackIdx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (DACK[i]) begin
                w_dackIdx = c_CHW'(i);
            end
        end
    end

    assign w_adstbFall = r_adstbD & ~ADSTB;

    // A CPU write commits on the edge that sees nIOW high after a low sample;
    // the DMA controller owns the bus while AEN is high, so such writes drop.
    assign w_cpuWrite  = nIOW & ~r_nIowD & ~nCSPage & ~AEN;
    assign w_regIsPage = ({1'b0, RegAddr} < c_NUM_CH4);
    assign w_pageWr    = w_cpuWrite & w_regIsPage;
    assign w_statusWr  = w_cpuWrite & (RegAddr == c_REG_STAT);

    // A different one-hot DACK while valid starts a fresh service.
    assign w_newSvc    = (r_state == c_VALID) && AEN && w_dackOneHot &&
                         (w_dackIdx != r_chan);
    assign w_inService = (r_state == c_VALID) && AEN;

    // Wrap is only meaningful between two strobes of the same service.
    assign w_strobeDone = w_inService && w_adstbFall && !w_newSvc && r_prevValid;
    assign w_wrapInc    = w_strobeDone && (r_prevUpper == 8'hFF) && (r_upperLatch == 8'h00);
    assign w_wrapDec    = w_strobeDone && (r_prevUpper == 8'h00) && (r_upperLatch == 8'hFF);

    always_comb begin
        w_setMask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_setMask[i] = (w_wrapInc || w_wrapDec) && (r_chan == c_CHW'(i));
        end
    end

    assign w_clrMask = w_statusWr ? DBIn[NUM_CH-1:0] : '0;

    // ------------------------------------------------------------------
    // Register read path
    // ------------------------------------------------------------------
    always_comb begin
        w_statusByte = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            w_statusByte[i] = r_status[i];
        end
    end

    always_comb begin
        w_readData = 8'h00;
        if (w_regIsPage) begin
            w_readData = r_page[RegAddr[c_CHW-1:0]];
        end else if (RegAddr == c_REG_STAT) begin
            w_readData = w_statusByte;
        end
    end

    assign DBOE  = ~nCSPage & ~nIOR & ~AEN;
    assign DBOut = DBOE ? w_readData : 8'h00;

    // ------------------------------------------------------------------
    // Address FSM, upper-byte latch and previous-upper record
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= c_IDLE;
            r_nIowD      <= 1'b1;
            r_adstbD     <= 1'b0;
            r_upperLatch <= 8'h00;
            r_upperCur   <= 8'h00;
            r_prevUpper  <= 8'h00;
            r_prevValid  <= 1'b0;
            r_chan       <= '0;
        end else begin
            r_nIowD  <= nIOW;
            r_adstbD <= ADSTB;

            if (AEN && ADSTB) begin
                r_upperLatch <= DBIn;
            end

            case (r_state)
                c_IDLE: begin
                    r_prevValid <= 1'b0;
                    if (AEN) begin
                        r_state <= c_WAIT_STB;
                    end
                end

                c_WAIT_STB: begin
                    if (!AEN) begin
                        r_state     <= c_IDLE;
                        r_prevValid <= 1'b0;
                    end else if (w_adstbFall && w_dackOneHot) begin
                        // First strobe of the service: no wrap check possible.
                        r_state     <= c_VALID;
                        r_chan      <= w_dackIdx;
                        r_upperCur  <= r_upperLatch;
                        r_prevUpper <= r_upperLatch;
                        r_prevValid <= 1'b1;
                    end
                end

                c_VALID: begin
                    if (!AEN) begin
                        r_state     <= c_IDLE;
                        r_prevValid <= 1'b0;
                    end else begin
                        if (w_newSvc) begin
                            r_chan <= w_dackIdx;
                        end
                        if (w_adstbFall) begin
                            r_upperCur  <= r_upperLatch;
                            r_prevUpper <= r_upperLatch;
                            r_prevValid <= 1'b1;
                        end else if (w_newSvc) begin
                            r_prevValid <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_prevValid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Page registers: CPU write, plus optional wrap-driven page stepping
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_page[i] <= PAGE_RST;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_pageWr && (RegAddr[c_CHW-1:0] == c_CHW'(i))) begin
                    r_page[i] <= DBIn;
                end
`ifdef DMA_AUTO_PAGE_INC_EN
                // Steps on the same edge that commits the new upper byte, so
                // the next SysAddr carries both together.
                else if (w_wrapInc && (r_chan == c_CHW'(i))) begin
                    r_page[i] <= r_page[i] + 8'd1;
                end else if (w_wrapDec && (r_chan == c_CHW'(i))) begin
                    r_page[i] <= r_page[i] - 8'd1;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky wrap status (set beats write-1-to-clear) and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_status  <= '0;
            r_wrapIrq <= 1'b0;
        end else begin
            r_status  <= (r_status & ~w_clrMask) | w_setMask;
            r_wrapIrq <= |r_status;
        end
    end

    // ------------------------------------------------------------------
    // Registered system address
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_addrValid <= 1'b0;
            r_sysAddr   <= 24'h000000;
        end else begin
            r_addrValid <= w_inService;
            r_sysAddr   <= w_inService ? {r_page[r_chan], r_upperCur, A7_A0} : 24'h000000;
        end
    end

    assign SysAddr   = r_sysAddr;
    assign AddrValid = r_addrValid;
    assign WrapIrq   = r_wrapIrq;

endmodule
`default_nettype wire

// File: tb/tb_dma_page_address_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_page_address_unit
// Description : Self-checking bench for dma_page_address_unit. A transaction
//               level model tracks pages, wrap status and the current service;
//               a compare process checks SysAddr/AddrValid/WrapIrq each cycle
//               once the outputs have settled after an event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_page_address_unit;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        nCSPage;
    logic        nIOW;
    logic        nIOR;
    logic [2:0]  RegAddr;
    logic [7:0]  DBIn;
    logic [7:0]  DBOut;
    logic        DBOE;
    logic        ADSTB;
    logic        AEN;
    logic [7:0]  A7_A0;
    logic [3:0]  DACK;
    logic [23:0] SysAddr;
    logic        AddrValid;
    logic        WrapIrq;

    dma_page_address_unit #(.NUM_CH(4), .PAGE_RST(8'h00)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .nCSPage  (nCSPage),
        .nIOW     (nIOW),
        .nIOR     (nIOR),
        .RegAddr  (RegAddr),
        .DBIn     (DBIn),
        .DBOut    (DBOut),
        .DBOE     (DBOE),
        .ADSTB    (ADSTB),
        .AEN      (AEN),
        .A7_A0    (A7_A0),
        .DACK     (DACK),
        .SysAddr  (SysAddr),
        .AddrValid(AddrValid),
        .WrapIrq  (WrapIrq)
    );

    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    logic [7:0] mPage [4];
    logic [3:0] mStatus;
    bit         mAen;
    bit         mValid;
    bit         mHavePrev;
    int         mCh;
    logic [7:0] mPrev;
    logic [7:0] mUpper;
    logic [7:0] mLow;
    logic [3:0] mDack;

    int nTests = 0;
    int nFail  = 0;
    bit checkEn = 0;

    function automatic int idxOf(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (d[i]) return i;
        return 0;
    endfunction

    function automatic logic [23:0] expAddr();
        return mValid ? {mPage[mCh], mUpper, mLow} : 24'h000000;
    endfunction

    function automatic logic [7:0] modelRead(input int a);
        if (a < 4) return mPage[a];
        if (a == 4) return {4'h0, mStatus};
        return 8'h00;
    endfunction

    task automatic mReset();
        for (int i = 0; i < 4; i++) mPage[i] = 8'h00;
        mStatus = 4'h0; mAen = 0; mValid = 0; mHavePrev = 0;
        mCh = 0; mPrev = 8'h00; mUpper = 8'h00; mDack = 4'h0;
    endtask

    task automatic mStrobe(input logic [7:0] u);
        if (!mAen) return;
        if (!mValid) begin
            if ($countones(mDack) == 1) begin
                mValid = 1; mCh = idxOf(mDack);
                mUpper = u; mPrev = u; mHavePrev = 1;
            end
        end else begin
            if (mHavePrev && mPrev == 8'hFF && u == 8'h00) begin
                mStatus[mCh] = 1'b1;
`ifdef DMA_AUTO_PAGE_INC_EN
                mPage[mCh] = mPage[mCh] + 8'd1;
`endif
            end else if (mHavePrev && mPrev == 8'h00 && u == 8'hFF) begin
                mStatus[mCh] = 1'b1;
`ifdef DMA_AUTO_PAGE_INC_EN
                mPage[mCh] = mPage[mCh] - 8'd1;
`endif
            end
            mUpper = u; mPrev = u; mHavePrev = 1;
        end
    endtask

    task automatic mWrite(input int a, input logic [7:0] d);
        if (mAen) return;
        if (a < 4) mPage[a] = d;
        else if (a == 4) mStatus = mStatus & ~d[3:0];
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (checkEn) begin
            check("SysAddr", 32'(SysAddr), 32'(expAddr()));
            check("AddrValid", 32'(AddrValid), 32'(mValid));
            check("WrapIrq", 32'(WrapIrq), 32'(|mStatus));
        end
    end

    task automatic settle();
        repeat (3) @(posedge Clock);
        checkEn = 1;
        repeat (2) @(negedge Clock);
        #1 checkEn = 0;
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic aenOn(input logic [3:0] d);
        @(negedge Clock);
        AEN = 1'b1; DACK = d;
        mAen = 1; mValid = 0; mHavePrev = 0; mDack = d;
        settle();
    endtask

    task automatic aenOff();
        @(negedge Clock);
        AEN = 1'b0; DACK = 4'h0;
        mAen = 0; mValid = 0; mHavePrev = 0; mDack = 4'h0;
        settle();
    endtask

    task automatic dackChange(input logic [3:0] d);
        @(negedge Clock);
        DACK = d;
        mDack = d;
        if (mValid && $countones(d) == 1 && idxOf(d) != mCh) begin
            mCh = idxOf(d); mHavePrev = 0;
        end
        settle();
    endtask

    task automatic lowByte(input logic [7:0] b);
        @(negedge Clock);
        A7_A0 = b; mLow = b;
        settle();
    endtask

    task automatic strobe(input logic [7:0] u);
        @(negedge Clock);
        DBIn = u; ADSTB = 1'b1;
        @(negedge Clock);
        ADSTB = 1'b0;
        mStrobe(u);
        settle();
    endtask

    task automatic cpuWrite(input int a, input logic [7:0] d);
        @(negedge Clock);
        RegAddr = 3'(a); DBIn = d; nCSPage = 1'b0; nIOW = 1'b0;
        @(negedge Clock);
        nIOW = 1'b1;
        mWrite(a, d);
        repeat (2) @(negedge Clock);
        nCSPage = 1'b1;
    endtask

    task automatic cpuRead(input int a, input logic [7:0] exp, input string name);
        @(negedge Clock);
        RegAddr = 3'(a); nCSPage = 1'b0; nIOR = 1'b0;
        #1;
        check({name, " DBOE"}, 32'(DBOE), 32'(!mAen));
        if (!mAen) check(name, 32'(DBOut), 32'(exp));
        @(negedge Clock);
        nIOR = 1'b1; nCSPage = 1'b1;
    endtask

    function automatic logic [3:0] randDack();
        if ($urandom_range(0, 3) != 0) return 4'(1 << $urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [7:0] randUpper();
        case ($urandom_range(0, 2))
            0: return 8'h00;
            1: return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        nReset = 1'b0; nCSPage = 1'b1; nIOW = 1'b1; nIOR = 1'b1;
        RegAddr = 3'd0; DBIn = 8'h00; ADSTB = 1'b0; AEN = 1'b0;
        A7_A0 = 8'h00; DACK = 4'h0;
        mReset(); mLow = 8'h00;
        repeat (3) @(negedge Clock);
        nReset = 1'b1;
        settle();

        // Reset state
        for (int a = 0; a < 5; a++) cpuRead(a, 8'h00, "reset read");
        check("reset AddrValid", 32'(AddrValid), 32'h0);
        check("reset SysAddr", 32'(SysAddr), 32'h0);

        // Basic service on channel 2
        cpuWrite(2, 8'h3C);
        aenOn(4'b0100);
        lowByte(8'h34);
        strobe(8'h12);
        check("svc AddrValid", 32'(AddrValid), 32'h1);
        check("svc SysAddr", 32'(SysAddr), 32'h3C1234);

        // Increment wrap within the service
        strobe(8'hFF);
        lowByte(8'h00);
        strobe(8'h00);
        check("inc wrap WrapIrq", 32'(WrapIrq), 32'h1);
`ifdef DMA_AUTO_PAGE_INC_EN
        check("inc wrap SysAddr", 32'(SysAddr), 32'h3D0000);
`else
        check("inc wrap SysAddr", 32'(SysAddr), 32'h3C0000);
`endif
        // Decrement wrap back
        strobe(8'hFF);
        check("dec wrap SysAddr", 32'(SysAddr), 32'h3CFF00);

        // Status clear attempt coinciding with a wrap
        @(negedge Clock);
        DBIn = 8'h00; ADSTB = 1'b1; RegAddr = 3'd4; nCSPage = 1'b0; nIOW = 1'b0;
        @(negedge Clock);
        ADSTB = 1'b0; nIOW = 1'b1; DBIn = 8'h04;
        mStrobe(8'h00);
        mWrite(4, 8'h04);
        repeat (2) @(negedge Clock);
        nCSPage = 1'b1;
        settle();
        check("clear+wrap WrapIrq", 32'(WrapIrq), 32'h1);
        aenOff();
        cpuRead(4, 8'h04, "status after clear+wrap");
        cpuWrite(4, 8'h04);
        cpuRead(4, 8'h00, "status after clear");
        settle();
        check("cleared WrapIrq", 32'(WrapIrq), 32'h0);

        // Non-one-hot DACK and write while AEN high
        aenOn(4'b0011);
        strobe(8'h55);
        check("bad DACK AddrValid", 32'(AddrValid), 32'h0);
        cpuRead(0, 8'h00, "read under AEN");
        cpuWrite(1, 8'hA5);
        aenOff();
        cpuRead(1, 8'h00, "page1 after AEN write");

        // Asynchronous reset mid-service
        aenOn(4'b0001);
        strobe(8'h9A);
        check("pre-reset AddrValid", 32'(AddrValid), 32'h1);
        @(negedge Clock);
        nReset = 1'b0;
        #1;
        check("async reset AddrValid", 32'(AddrValid), 32'h0);
        check("async reset SysAddr", 32'(SysAddr), 32'h0);
        mReset();
        AEN = 1'b0; DACK = 4'h0;
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        settle();
        for (int a = 0; a < 4; a++) cpuRead(a, 8'h00, "page after reset");

        // Randomized services
        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < 2; k++) cpuWrite($urandom_range(0, 3), randUpper());
            aenOn(randDack());
            lowByte(8'($urandom_range(0, 255)));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: strobe(randUpper());
                    6, 7: lowByte(8'($urandom_range(0, 255)));
                    default: dackChange(randDack());
                endcase
            end
            aenOff();
            if ($urandom_range(0, 2) == 0) cpuWrite(4, 8'($urandom_range(0, 15)));
            for (int a = 0; a < 8; a++) cpuRead(a, modelRead(a), "random read");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
